// File: rtl/sync_pkg.sv
// Shared constants and helpers for the clkB-side input synchroniser family.
package sync_pkg;

  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int SYNC_FILTER_LEN_DEFAULT = 4;

  // Width of a counter that must hold 0 .. filterLen; never narrower than one bit.
  function automatic int cntWidth(input int filterLen);
    int w;
    w = $clog2(filterLen + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel after the sync chain: optional glitch filter (SYNC_BUS_FILTER_EN),
// output level register and registered rise/fall pulses.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   FILTER_LEN = SYNC_FILTER_LEN_DEFAULT,
  parameter logic RESET_BIT  = 1'b0
) (
  input  logic clkB,
  input  logic rstB,
  input  logic syncIn,
  output logic levelOut,
  output logic rise,
  output logic fall
);

  if (FILTER_LEN < 1) begin : gBadFilterLen
    $error("sync_filter_ch: FILTER_LEN must be >= 1");
  end

`ifdef SYNC_BUS_FILTER_EN
  localparam int            CW       = cntWidth(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt;

  // Filter stage: a new level is taken only after FILTER_LEN disagreeing samples in a row;
  // the counter clears on acceptance, so it can never pass CNT_LAST.
  always_ff @(posedge clkB) begin
    if (rstB) begin
      cnt      <= '0;
      levelOut <= RESET_BIT;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (syncIn == levelOut) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        levelOut <= syncIn;
        rise     <= syncIn;
        fall     <= ~syncIn;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
`else
  // Bypass stage: the output follows the synchronised level one cycle later.
  always_ff @(posedge clkB) begin
    if (rstB) begin
      levelOut <= RESET_BIT;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      levelOut <= syncIn;
      rise     <= syncIn & ~levelOut;
      fall     <= ~syncIn & levelOut;
    end
  end
`endif

endmodule

// File: rtl/sync_bus_filter.sv
// WIDTH-channel synchroniser into clkB with per-channel edge pulses.
// Define SYNC_BUS_FILTER_EN to add the FILTER_LEN-cycle glitch filter.
module sync_bus_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = SYNC_STAGES_DEFAULT,
  parameter int               FILTER_LEN = SYNC_FILTER_LEN_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clkB,
  input  logic             rstB,
  input  logic [WIDTH-1:0] SignalIn,
  output logic [WIDTH-1:0] SignalOut_clkB,
  output logic [WIDTH-1:0] rise_clkB,
  output logic [WIDTH-1:0] fall_clkB
);

  if (STAGES < 2) begin : gBadStages
    $error("sync_bus_filter: STAGES must be >= 2");
  end

  // Channels are independent; the bus is only shifted together for compactness.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] syncStage [STAGES];

  // Sync chain stage boundary: SignalIn -> syncStage[0] -> ... -> syncStage[STAGES-1].
  always_ff @(posedge clkB) begin
    if (rstB) begin
      for (int k = 0; k < STAGES; k++) begin
        syncStage[k] <= RESET_VAL;
      end
    end else begin
      syncStage[0] <= SignalIn;
      for (int k = 1; k < STAGES; k++) begin
        syncStage[k] <= syncStage[k-1];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gCh
    sync_filter_ch #(
      .FILTER_LEN (FILTER_LEN),
      .RESET_BIT  (RESET_VAL[i])
    ) uCh (
      .clkB     (clkB),
      .rstB     (rstB),
      .syncIn   (syncStage[STAGES-1][i]),
      .levelOut (SignalOut_clkB[i]),
      .rise     (rise_clkB[i]),
      .fall     (fall_clkB[i])
    );
  end

endmodule

// File: tb/tb_sync_bus_filter.sv
// Directed bench for sync_bus_filter (4 channels, RESET_VAL 4'b1010), filtered or bypass build.
module tb_sync_bus_filter;

  localparam int         W  = 4;
  localparam int         FL = 4;
  localparam logic [3:0] RV = 4'b1010;
`ifdef SYNC_BUS_FILTER_EN
  localparam int         ST        = 2;
  localparam int         LAT       = 5;
  localparam logic       G3_EXP    = 1'b0;
  localparam logic       G1_EXP    = 1'b0;
  localparam int         FALL2_OFF = 9;
  localparam int         FALL3_OFF = 13;
  localparam logic [3:0] IND_RISE  = 4'b1100;
`else
  localparam int         ST        = 3;
  localparam int         LAT       = 3;
  localparam logic       G3_EXP    = 1'b1;
  localparam logic       G1_EXP    = 1'b1;
  localparam int         FALL2_OFF = 7;
  localparam int         FALL3_OFF = 11;
  localparam logic [3:0] IND_RISE  = 4'b1111;
`endif

  logic         clkB = 1'b0;
  logic         rstB;
  logic [W-1:0] SignalIn;
  logic [W-1:0] SignalOut_clkB;
  logic [W-1:0] rise_clkB;
  logic [W-1:0] fall_clkB;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;

  always #5 clkB = ~clkB;

  sync_bus_filter #(
    .WIDTH      (W),
    .STAGES     (ST),
    .FILTER_LEN (FL),
    .RESET_VAL  (RV)
  ) dut (
    .clkB           (clkB),
    .rstB           (rstB),
    .SignalIn       (SignalIn),
    .SignalOut_clkB (SignalOut_clkB),
    .rise_clkB      (rise_clkB),
    .fall_clkB      (fall_clkB)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edgeCnt, act, exp);
    end
  endtask

  task automatic waitEdge(input int t);
    while (edgeCnt < t) begin
      @(posedge clkB);
      #1;
    end
  endtask

  // Behavioural model: a STAGES-deep delay of the input, then a level is accepted once the
  // last FILTER_LEN delayed samples since reset all disagree with the current output.
  logic [3:0] capt [ST];
  logic [3:0] hist [$];
  logic [3:0] expOut, expRise, expFall, slv, newOut;
  bit         modelValid = 0;
  bit         allDiff;

  always begin
    @(posedge clkB);
    edgeCnt++;
    if (rstB) begin
      for (int k = 0; k < ST; k++) capt[k] = RV;
      hist.delete();
      expOut  = RV;
      expRise = '0;
      expFall = '0;
      modelValid = 1;
    end else begin
      slv = capt[ST-1];
      for (int k = ST - 1; k > 0; k--) capt[k] = capt[k-1];
      capt[0] = SignalIn;
      hist.push_back(slv);
      if (hist.size() > FL) void'(hist.pop_front());
`ifdef SYNC_BUS_FILTER_EN
      newOut = expOut;
      for (int c = 0; c < W; c++) begin
        if (hist.size() == FL) begin
          allDiff = 1;
          foreach (hist[j]) if (hist[j][c] == expOut[c]) allDiff = 0;
          if (allDiff) newOut[c] = ~expOut[c];
        end
      end
`else
      newOut = slv;
`endif
      expRise = newOut & ~expOut;
      expFall = ~newOut & expOut;
      expOut  = newOut;
    end
    #1;
    if (modelValid) begin
      chk("model_out",  SignalOut_clkB, expOut);
      chk("model_rise", rise_clkB,      expRise);
      chk("model_fall", fall_clkB,      expFall);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r;
    rstB     = 1'b1;
    SignalIn = 4'b0101;
    repeat (3) @(posedge clkB);
    #1;
    chk("reset_out",  SignalOut_clkB, 4'b1010);
    chk("reset_rise", rise_clkB,      4'b0000);
    chk("reset_fall", fall_clkB,      4'b0000);

    @(negedge clkB);
    rstB     = 1'b0;
    SignalIn = 4'b0000;
    repeat (14) @(posedge clkB);
    #1;
    chk("settle_out", SignalOut_clkB, 4'b0000);

    // Clean rising edge on bit 0
    @(negedge clkB);
    SignalIn[0] = 1'b1;
    e0 = edgeCnt + 1;
    waitEdge(e0 + LAT - 1);
    chk("clean_pre_out0",  {3'b0, SignalOut_clkB[0]}, 4'd0);
    waitEdge(e0 + LAT);
    chk("clean_out0",      {3'b0, SignalOut_clkB[0]}, 4'd1);
    chk("clean_rise0",     {3'b0, rise_clkB[0]},      4'd1);
    chk("clean_fall0",     {3'b0, fall_clkB[0]},      4'd0);
    waitEdge(e0 + LAT + 1);
    chk("clean_rise0_end", {3'b0, rise_clkB[0]},      4'd0);

    // Three-cycle high on bit 1
    @(negedge clkB);
    SignalIn[1] = 1'b1;
    e0 = edgeCnt + 1;
    repeat (3) @(negedge clkB);
    SignalIn[1] = 1'b0;
    waitEdge(e0 + LAT);
    chk("glitch3_out1",  {3'b0, SignalOut_clkB[1]}, {3'b0, G3_EXP});
    chk("glitch3_rise1", {3'b0, rise_clkB[1]},      {3'b0, G3_EXP});

    // One-cycle high on bit 2
    @(negedge clkB);
    SignalIn[2] = 1'b1;
    e0 = edgeCnt + 1;
    @(negedge clkB);
    SignalIn[2] = 1'b0;
    waitEdge(e0 + LAT);
    chk("glitch1_out2",  {3'b0, SignalOut_clkB[2]}, {3'b0, G1_EXP});
    waitEdge(e0 + LAT + 1);
    chk("glitch1_fall2", {3'b0, fall_clkB[2]},      {3'b0, G1_EXP});
    chk("glitch1_post2", {3'b0, SignalOut_clkB[2]}, 4'd0);
    repeat (8) @(posedge clkB);

    // Four-cycle high on bit 1: accepted, rise then fall 4 cycles apart
    @(negedge clkB);
    SignalIn[1] = 1'b1;
    e0 = edgeCnt + 1;
    repeat (4) @(negedge clkB);
    SignalIn[1] = 1'b0;
    waitEdge(e0 + LAT);
    chk("pulse4_rise1",     {3'b0, rise_clkB[1]},      4'd1);
    chk("pulse4_out1",      {3'b0, SignalOut_clkB[1]}, 4'd1);
    waitEdge(e0 + LAT + 1);
    chk("pulse4_rise1_end", {3'b0, rise_clkB[1]},      4'd0);
    waitEdge(e0 + LAT + 4);
    chk("pulse4_fall1",     {3'b0, fall_clkB[1]},      4'd1);
    chk("pulse4_out1_low",  {3'b0, SignalOut_clkB[1]}, 4'd0);

    // Reset in the middle of a bit-3 falling qualification
    @(negedge clkB);
    SignalIn[3] = 1'b1;
    repeat (10) @(negedge clkB);
    SignalIn[3] = 1'b0;
    e0 = edgeCnt + 1;
    repeat (4) @(negedge clkB);
    rstB = 1'b1;
    r = edgeCnt + 1;
    @(negedge clkB);
    rstB = 1'b0;
    waitEdge(r);
    chk("midrst_out",   SignalOut_clkB, 4'b1010);
    waitEdge(r + LAT);
    chk("midrst_hold3", {3'b0, SignalOut_clkB[3]}, 4'd1);
    chk("midrst_nof3",  {3'b0, fall_clkB[3]},      4'd0);
    waitEdge(r + 1 + LAT);
    chk("midrst_out3",  {3'b0, SignalOut_clkB[3]}, 4'd0);
    chk("midrst_fall3", {3'b0, fall_clkB[3]},      4'd1);

    @(negedge clkB);
    SignalIn = 4'b0000;
    repeat (15) @(posedge clkB);
    #1;
    chk("settle2_out", SignalOut_clkB, 4'b0000);

    // Independence: all bits high together, held for 1, 3, 4, 8 cycles
    @(negedge clkB);
    SignalIn = 4'b1111;
    e0 = edgeCnt + 1;
    fork
      begin
        for (int i = 1; i < 10; i++) begin
          @(negedge clkB);
          SignalIn = {i < 8, i < 4, i < 3, i < 1};
        end
      end
      begin
        waitEdge(e0 + LAT);
        chk("indep_rise",  rise_clkB, IND_RISE);
        waitEdge(e0 + FALL2_OFF);
        chk("indep_fall2", fall_clkB, 4'b0100);
        waitEdge(e0 + FALL3_OFF);
        chk("indep_fall3", fall_clkB, 4'b1000);
      end
    join

    repeat (5) @(posedge clkB);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_bus_filter.md
# sync_bus_filter

Parametrised multi-channel input synchroniser for the clkB domain, the successor to the fixed two-flop single-bit synchroniser. Each of WIDTH independent asynchronous inputs passes through a STAGES-deep shift register. An optional per-channel glitch filter then accepts a new level only after it has been stable for FILTER_LEN consecutive clkB cycles. The block also reports single-cycle rise and fall pulses. It sits at the boundary of every clkB-side consumer of external or foreign-domain level signals (buttons, status lines, quasi-static flags).

## Interface
- WIDTH, 1, number of independent channels
- STAGES, 2, synchroniser depth; must be ≥ 2
- FILTER_LEN, 4, consecutive stable cycles required to accept a new level; must be ≥ 1; ignored without SYNC_BUS_FILTER_EN
- RESET_VAL, {WIDTH{1'b0}}, per-channel reset level of the sync stages and output
- clkB  input  1  destination clock; all logic on posedge
- rstB  input  1  synchronous, active-high reset
- SignalIn  input  WIDTH  asynchronous levels, one bit per channel
- SignalOut_clkB  output  WIDTH  synchronised (and filtered) levels
- rise_clkB  output  WIDTH  one-cycle pulse when SignalOut_clkB bit goes 0→1
- fall_clkB  output  WIDTH  one-cycle pulse when SignalOut_clkB bit goes 1→0

## Operation
- Channels are fully independent; no bus coherence is implied. Multi-bit values needing coherence must not use this block.
- Sync chain per channel: s[0] <= SignalIn[i], s[k] <= s[k-1]. Let sl = s[STAGES-1].
- Output register out[i] drives SignalOut_clkB[i]. Pulses are registered at the same edge as out.
- Filter mode, per channel, counter cnt of width $clog2(FILTER_LEN+1):
  - sl == out: cnt <= 0.
  - sl != out and cnt < FILTER_LEN-1: cnt <= cnt+1.
  - sl != out and cnt == FILTER_LEN-1: out <= sl, cnt <= 0, and the matching rise or fall pulse is asserted for one cycle.
- A disagreement lasting fewer than FILTER_LEN cycles resets cnt and never changes out; no pulse.
- Counter saturation is impossible by construction, since it clears on acceptance.
- Bypass mode (no macro): out <= sl every cycle. rise = sl & ~out, fall = ~sl & out, both registered.
- Pulses: rise and fall are never both high on the same bit. Consecutive accepted toggles produce consecutive, non-overlapping pulses.
- Reset (rstB high at posedge):
  - all s[k] <= RESET_VAL, out <= RESET_VAL, cnt <= 0, rise/fall <= 0.
  - Reset mid-filter discards the partial count.
  - The first cycle after reset produces no pulse unless the input differs from RESET_VAL through the full latency.
- Elaboration error if STAGES < 2 or FILTER_LEN < 1.

## Timing
- Input change captured at edge E0 reaches sl at edge E0+STAGES-1.
- Bypass: SignalOut_clkB and the pulse change at E0+STAGES.
- Filter: SignalOut_clkB and the pulse change at E0+STAGES+FILTER_LEN-1. With FILTER_LEN=1 this equals bypass latency.
- Pulse width is exactly one clkB cycle.
- Minimum accepted pulse width at the input is FILTER_LEN cycles after capture jitter of ±1 cycle.
- No combinational path from any input to any output.

## Configuration
- SYNC_BUS_FILTER_EN defined: glitch-filter counters are instantiated; latency is STAGES+FILTER_LEN-1.
- SYNC_BUS_FILTER_EN undefined: no counters; FILTER_LEN has no effect; latency is STAGES; rise/fall still generated.

## Structure
- Shared package sync_pkg:
  - SYNC_STAGES_DEFAULT = 2, SYNC_FILTER_LEN_DEFAULT = 4.
  - Counter-width helper function based on $clog2.
- Sub-module sync_filter_ch: one channel's counter, out register and pulse generation, parameterised by FILTER_LEN and its reset bit.
- The top level is a generate loop over WIDTH, plus the sync chains.
- Sync flops carry the team's synchroniser attribute; filter and output flops do not.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'b1010, rstB high 3 cycles with SignalIn=4'b0101 → SignalOut_clkB=4'b1010 and rise=fall=0 throughout reset.
- Clean edge, filter on: STAGES=2, FILTER_LEN=4, bit0 0→1 captured at edge 10 → SignalOut_clkB[0]=1 and rise_clkB[0]=1 at edge 15 only, fall stays 0.
- Glitch reject: bit1 high for 3 cycles then low, FILTER_LEN=4 → SignalOut_clkB[1] stays 0, no pulses. With a 4-cycle high → accepted, rise then fall pulses 4 cycles apart.
- Bypass build (macro undefined), STAGES=3: bit2 toggled at edge 20 → output and pulse at edge 23. A 1-cycle input glitch propagates as a 1-cycle output.
- Reset mid-filter: bit3 differs from out, cnt=2, rstB asserted one cycle → cnt cleared. After release, a full 4-cycle stability is needed before the output changes.
- Independence: all 4 bits toggled with different stable durations (1,3,4,8 cycles) → only channels with ≥4 change; pulses align per channel with the computed latency.
